// File: rtl/pacman_pkg.sv
// Shared Pac-Man maze types: tile encoding, collision codes, maze defaults and the
// collision detector FSM states.
package pacman_pkg;

    localparam int unsigned DefCols = 28;
    localparam int unsigned DefRows = 31;

    typedef enum logic [1:0] {
        TileEmpty = 2'b00,
        TilePill  = 2'b01,
        TilePower = 2'b10,
        TileWall  = 2'b11
    } tile_t;

    // One-hot codes, consumed by the pill counter and score/ghost logic.
    typedef logic [3:0] collision_t;
    localparam collision_t CollNone  = 4'b0000;
    localparam collision_t CollWall  = 4'b0001;
    localparam collision_t CollPill  = 4'b0010;
    localparam collision_t CollPower = 4'b0100;
    localparam collision_t CollGhost = 4'b1000;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StClassify,
        StReport
    } state_t;

    function automatic logic is_edible(input tile_t t);
        return (t == TilePill) || (t == TilePower);
    endfunction

endpackage

// File: rtl/ghost_match.sv
// Combinational check: is any ghost standing on Pac-Man's tile.
module ghost_match #(
    parameter int unsigned NUM_GHOSTS = 4
) (
    input  logic [4:0]              pac_x,
    input  logic [4:0]              pac_y,
    input  logic [5*NUM_GHOSTS-1:0] ghost_x,
    input  logic [5*NUM_GHOSTS-1:0] ghost_y,
    output logic                    hit
);

    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
            if ((ghost_x[5*i +: 5] == pac_x) && (ghost_y[5*i +: 5] == pac_y)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/collision_detector.sv
// Per-move tile lookup, ghost check, pill clearing and edible tracking for Pac-Man.
// Ghost detection is compiled in only when COLLISION_GHOST_EN is defined.
module collision_detector
    import pacman_pkg::*;
#(
    parameter int unsigned COLS          = DefCols,
    parameter int unsigned ROWS          = DefRows,
    parameter int unsigned NUM_GHOSTS    = 4,
    parameter int unsigned RD_LAT        = 1,
    parameter int unsigned TOTAL_EDIBLES = 244
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    move_valid,
    input  logic [4:0]              pac_x,
    input  logic [4:0]              pac_y,
    input  logic [5*NUM_GHOSTS-1:0] ghost_x,
    input  logic [5*NUM_GHOSTS-1:0] ghost_y,
    output logic [9:0]              tile_addr,
    input  logic [1:0]              tile_rdata,
    output logic                    tile_we,
    output logic [1:0]              tile_wdata,
    output logic [3:0]              collision_type,
    output logic                    busy,
    output logic                    level_clear
);

    localparam logic [7:0] WaitLast   = (RD_LAT > 1) ? 8'(RD_LAT - 2) : 8'd0;
    localparam logic [7:0] EdibleInit = 8'(TOTAL_EDIBLES);

    state_t     state_q, state_d;
    logic [4:0] pos_x_q, pos_x_d;
    logic [4:0] pos_y_q, pos_y_d;
    logic       oor_q, oor_d;
    logic [9:0] addr_q, addr_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    collision_t code_q, code_d;
    logic       edible_q, edible_d;
    logic [7:0] edible_cnt_q, edible_cnt_d;

    logic       ghost_hit;
    logic       oor_now;
    logic [9:0] addr_now;
    tile_t      tile;

    assign oor_now  = (32'(pac_x) >= COLS) || (32'(pac_y) >= ROWS);
    assign addr_now = 10'(32'(pac_y) * COLS + 32'(pac_x));
    assign tile     = tile_t'(tile_rdata);

`ifdef COLLISION_GHOST_EN
    ghost_match #(
        .NUM_GHOSTS(NUM_GHOSTS)
    ) u_ghost_match (
        .pac_x  (pos_x_q),
        .pac_y  (pos_y_q),
        .ghost_x(ghost_x),
        .ghost_y(ghost_y),
        .hit    (ghost_hit)
    );
`else
    logic unused_ghost;
    assign unused_ghost = ^{ghost_x, ghost_y};
    assign ghost_hit    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        oor_d        = oor_q;
        addr_d       = addr_q;
        wait_cnt_d   = wait_cnt_q;
        code_d       = code_q;
        edible_d     = edible_q;
        edible_cnt_d = edible_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (move_valid) begin
                    pos_x_d = pac_x;
                    pos_y_d = pac_y;
                    oor_d   = oor_now;
                    addr_d  = oor_now ? 10'd0 : addr_now;
                    state_d = StRead;
                end
            end
            StRead: begin
                wait_cnt_d = 8'd0;
                state_d    = (RD_LAT > 1) ? StWait : StClassify;
            end
            StWait: begin
                if (wait_cnt_q == WaitLast) begin
                    state_d = StClassify;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StClassify: begin
                // An edible tile under a ghost is still eaten; only the reported code changes.
                edible_d = !oor_q && is_edible(tile);
                if (ghost_hit) begin
                    code_d = CollGhost;
                end else if (oor_q) begin
                    code_d = CollWall;
                end else begin
                    unique case (tile)
                        TilePill:  code_d = CollPill;
                        TilePower: code_d = CollPower;
                        TileWall:  code_d = CollWall;
                        default:   code_d = CollNone;
                    endcase
                end
                state_d = StReport;
            end
            StReport: begin
                if (edible_q && (edible_cnt_q != 8'd0)) begin
                    edible_cnt_d = edible_cnt_q - 8'd1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= StIdle;
            pos_x_q      <= 5'd0;
            pos_y_q      <= 5'd0;
            oor_q        <= 1'b0;
            addr_q       <= 10'd0;
            wait_cnt_q   <= 8'd0;
            code_q       <= CollNone;
            edible_q     <= 1'b0;
            edible_cnt_q <= EdibleInit;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            oor_q        <= oor_d;
            addr_q       <= addr_d;
            wait_cnt_q   <= wait_cnt_d;
            code_q       <= code_d;
            edible_q     <= edible_d;
            edible_cnt_q <= edible_cnt_d;
        end
    end

    assign tile_addr      = addr_q;
    assign tile_wdata     = TileEmpty;
    assign busy           = (state_q != StIdle);
    assign collision_type = (state_q == StReport) ? code_q : CollNone;
    assign tile_we        = (state_q == StReport) && edible_q;
    assign level_clear    = (state_q == StReport) && edible_q && (edible_cnt_q == 8'd1);

endmodule

// File: tb/tb_collision_detector.sv
// Bench for collision_detector: behavioural tile RAM plus a scoreboard of expected reports.
module tb_collision_detector;
    import pacman_pkg::*;

    localparam int unsigned NG = 4;

`ifdef COLLISION_GHOST_EN
    localparam collision_t GhostOnPower = CollGhost;
    localparam collision_t GhostOnWall  = CollGhost;
`else
    localparam collision_t GhostOnPower = CollPower;
    localparam collision_t GhostOnWall  = CollWall;
`endif

    typedef struct packed {
        logic [3:0] code;
        logic       we;
        logic [9:0] addr;
        logic [1:0] wdata;
        logic       lvl;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            move_valid = 1'b0;
    logic [4:0]      pac_x = 5'd0;
    logic [4:0]      pac_y = 5'd0;
    logic [5*NG-1:0] ghost_x = {NG{5'd31}};
    logic [5*NG-1:0] ghost_y = {NG{5'd31}};
    logic [9:0]      tile_addr;
    logic [1:0]      tile_rdata;
    logic            tile_we;
    logic [1:0]      tile_wdata;
    logic [3:0]      collision_type;
    logic            busy;
    logic            level_clear;

    logic [1:0] mem [0:1023];

    exp_t sb [$];
    exp_t obs;
    int   pulses;
    logic busy_ok;
    int   checks = 0;
    int   errors = 0;

    collision_detector #(
        .COLS         (28),
        .ROWS         (31),
        .NUM_GHOSTS   (NG),
        .RD_LAT       (1),
        .TOTAL_EDIBLES(4)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .move_valid    (move_valid),
        .pac_x         (pac_x),
        .pac_y         (pac_y),
        .ghost_x       (ghost_x),
        .ghost_y       (ghost_y),
        .tile_addr     (tile_addr),
        .tile_rdata    (tile_rdata),
        .tile_we       (tile_we),
        .tile_wdata    (tile_wdata),
        .collision_type(collision_type),
        .busy          (busy),
        .level_clear   (level_clear)
    );

    always #10 clk = ~clk;

    // One-cycle-latency synchronous tile RAM.
    always @(posedge clk) begin
        tile_rdata <= mem[tile_addr];
        if (tile_we) mem[tile_addr] <= tile_wdata;
    end

    // Strobe one move, then sample the report cycle and count stray activity elsewhere.
    task automatic run_move(input logic [4:0] x, input logic [4:0] y);
        pulses  = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        pac_x      = x;
        pac_y      = y;
        move_valid = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 3) begin
                obs = '{code: collision_type, we: tile_we, addr: tile_addr,
                        wdata: tile_wdata, lvl: level_clear};
            end else if ((collision_type != 4'd0) || tile_we || level_clear) begin
                pulses++;
            end
            if (busy !== (n <= 3)) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, collision_type, tile_we, level_clear, tile_addr, tile_wdata} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b code=%b we=%b lvl=%b addr=%0d wdata=%b, expected all 0",
                     busy, collision_type, tile_we, level_clear, tile_addr, tile_wdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, collision_type, tile_we, level_clear} !== 7'd0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b code=%b we=%b lvl=%b, expected 0",
                     busy, collision_type, tile_we, level_clear);
        end
    endtask

    task automatic test_move(input string name, input logic [4:0] x, input logic [4:0] y,
                             input collision_t code, input logic we, input logic [9:0] addr,
                             input logic lvl);
        exp_t e;
        sb.push_back('{code: code, we: we, addr: addr, wdata: 2'b00, lvl: lvl});
        run_move(x, y);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s_report: got code=%b we=%b addr=%0d wdata=%b lvl=%b, expected code=%b we=%b addr=%0d wdata=%b lvl=%b",
                     name, obs.code, obs.we, obs.addr, obs.wdata, obs.lvl,
                     e.code, e.we, e.addr, e.wdata, e.lvl);
        end
        checks++;
        if ((pulses != 0) || !busy_ok) begin
            errors++;
            $display("FAIL %s_timing: got %0d stray pulses busy_ok=%b, expected 0 and 1",
                     name, pulses, busy_ok);
        end
    endtask

    task automatic test_pill;
        test_move("pill", 5'd1, 5'd1, CollPill, 1'b1, 10'd29, 1'b0);
        checks++;
        if (mem[29] !== TileEmpty) begin
            errors++;
            $display("FAIL pill_cleared: got %b expected 00", mem[29]);
        end
    endtask

    task automatic test_wall_none;
        test_move("wall", 5'd2, 5'd1, CollWall, 1'b0, 10'd30, 1'b0);
        test_move("none", 5'd0, 5'd2, CollNone, 1'b0, 10'd56, 1'b0);
    endtask

    task automatic test_ghost;
        ghost_x[14:10] = 5'd3;
        ghost_y[14:10] = 5'd1;
        test_move("ghost_power", 5'd3, 5'd1, GhostOnPower, 1'b1, 10'd31, 1'b0);
        checks++;
        if (mem[31] !== TileEmpty) begin
            errors++;
            $display("FAIL ghost_power_cleared: got %b expected 00", mem[31]);
        end
        ghost_x[14:10] = 5'd2;
        test_move("ghost_wall", 5'd2, 5'd1, GhostOnWall, 1'b0, 10'd30, 1'b0);
        ghost_x[14:10] = 5'd31;
        ghost_y[14:10] = 5'd31;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [3:0] seen_code;
        logic [9:0] seen_addr;
        seen_code = 4'd0;
        seen_addr = 10'd0;
        pulses = 0;
        sb.push_back('{code: CollPill, we: 1'b1, addr: 10'd57, wdata: 2'b00, lvl: 1'b0});
        @(negedge clk);
        pac_x      = 5'd1;
        pac_y      = 5'd2;
        move_valid = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if ((collision_type != 4'd0) || tile_we) begin
                pulses++;
                seen_code = collision_type;
                seen_addr = tile_addr;
            end
            pac_x      = 5'd2;
            move_valid = (n == 1) || (n == 3);
        end
        e = sb.pop_front();
        checks++;
        if ((pulses != 1) || (seen_code !== e.code) || (seen_addr !== e.addr)) begin
            errors++;
            $display("FAIL back_to_back: got %0d pulses code=%b addr=%0d, expected 1 pulse code=%b addr=%0d",
                     pulses, seen_code, seen_addr, e.code, e.addr);
        end
        checks++;
        if (mem[58] !== TilePill) begin
            errors++;
            $display("FAIL back_to_back_dropped: got tile %b expected 01", mem[58]);
        end
    endtask

    task automatic test_level_clear;
        test_move("last_pill", 5'd2, 5'd2, CollPill, 1'b1, 10'd58, 1'b1);
        test_move("saturate", 5'd3, 5'd2, CollPill, 1'b1, 10'd59, 1'b0);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        pac_x      = 5'd4;
        pac_y      = 5'd2;
        move_valid = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, collision_type, tile_we, level_clear, tile_addr} !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b code=%b we=%b lvl=%b addr=%0d, expected all 0",
                     busy, collision_type, tile_we, level_clear, tile_addr);
        end
        reset = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || (collision_type != 4'd0) || tile_we) pulses++;
        end
        checks++;
        if ((pulses != 0) || (mem[60] !== TilePill)) begin
            errors++;
            $display("FAIL reset_mid_abort: got %0d active cycles tile=%b, expected 0 and 01",
                     pulses, mem[60]);
        end
    endtask

    task automatic test_out_of_range;
        test_move("oor_x", 5'd28, 5'd0, CollWall, 1'b0, 10'd0, 1'b0);
        test_move("oor_y", 5'd1, 5'd31, CollWall, 1'b0, 10'd0, 1'b0);
        // Counter reloaded by the mid-move reset: 4 edibles left, no pulse.
        test_move("post_reset_pill", 5'd4, 5'd2, CollPill, 1'b1, 10'd60, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= TileEmpty;
        mem[0]  <= TilePill;
        mem[29] <= TilePill;
        mem[30] <= TileWall;
        mem[31] <= TilePower;
        mem[57] <= TilePill;
        mem[58] <= TilePill;
        mem[59] <= TilePill;
        mem[60] <= TilePill;

        test_reset();
        test_pill();
        test_wall_none();
        test_ghost();
        test_back_to_back();
        test_level_clear();
        test_reset_mid();
        test_out_of_range();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
